// File: rtl/sparse_pe_feeder_pkg.sv
// -----------------------------------------------------------------------------
// sparse_pe_feeder_pkg
// Shared types and constants for the sparse PE input-stream feeder.
//   - feed_state_t : read-sequencer FSM states
//   - beat_kind_t  : beat-type encoding carried down the output pipeline
//   - beat_tag_t   : per-read tag {kind, channel, last-of-run}
//   - field-offset helpers for the {value, row, col} memory element
// -----------------------------------------------------------------------------
package sparse_pe_feeder_pkg;

    localparam int WEIGHT_BEATS = 4;   // weight beats at the head of every channel
    localparam int LANES        = 4;   // activation lanes per beat
    localparam int CH_W         = 6;   // channel index width
    localparam int K_W          = $clog2(WEIGHT_BEATS);
    localparam int W_ADDR_W     = CH_W + K_W;  // weight address = {ch, k}
    localparam int PIXELS_W     = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH_W = 2'd1,
        FETCH_A = 2'd2,
        DRAIN   = 2'd3
    } feed_state_t;

    typedef enum logic {
        BEAT_ACT    = 1'b0,
        BEAT_WEIGHT = 1'b1
    } beat_kind_t;

    typedef struct packed {
        beat_kind_t      kind;
        logic [CH_W-1:0] ch;
        logic            last;   // final read of the whole run
    } beat_tag_t;

    // Memory element layout, MSB first: {value, row, col}.
    localparam int FIELD_COL_LSB = 0;

    function automatic int elem_w(input int wl, input int cl);
        return wl + 2 * cl;
    endfunction

    function automatic int row_lsb(input int cl);
        return cl;
    endfunction

    function automatic int val_lsb(input int cl);
        return 2 * cl;
    endfunction

endpackage

// File: rtl/sparse_feed_addr_gen.sv
// -----------------------------------------------------------------------------
// sparse_feed_addr_gen
// Read sequencer: walks channels, issuing 4 weight reads then act_beats
// activation reads per channel, one read every cycle with no bubbles.
// Ports:
//   clk, irst_n            clock, async active-low reset
//   start                  one-cycle layer request (ignored unless IDLE)
//   num_channels/act_beats layer shape, latched on an accepted start
//   w_rd_en/w_rd_addr      weight memory read port (addr = ch*4+k)
//   a_rd_en/a_rd_addr      activation memory read port (addr = ch*act_beats+j)
//   tag                    {kind, ch, last} aligned with the read issued
//   pixels                 act_beats+4, held for the run
//   busy                   run in progress
//   empty_done             one-cycle pulse answering a zero-sized start
// -----------------------------------------------------------------------------
module sparse_feed_addr_gen
    import sparse_pe_feeder_pkg::*;
#(
    parameter int ACT_BEAT_W = 12,
    parameter int A_ADDR_W   = 18
) (
    input  logic                  clk,
    input  logic                  irst_n,
    input  logic                  start,
    input  logic [CH_W-1:0]       num_channels,
    input  logic [ACT_BEAT_W-1:0] act_beats,
    output logic                  w_rd_en,
    output logic [W_ADDR_W-1:0]   w_rd_addr,
    output logic                  a_rd_en,
    output logic [A_ADDR_W-1:0]   a_rd_addr,
    output beat_tag_t             tag,
    output logic [PIXELS_W-1:0]   pixels,
    output logic                  busy,
    output logic                  empty_done
);

    localparam logic [ACT_BEAT_W-1:0] J_ONE = ACT_BEAT_W'(1);

    feed_state_t           state;
    logic [CH_W-1:0]       ch_q;
    logic [K_W-1:0]        k_q;
    logic [ACT_BEAT_W-1:0] j_q;
    logic [A_ADDR_W-1:0]   base_q;   // running ch*act_beats, no multiplier
    logic [CH_W-1:0]       num_ch_q;
    logic [ACT_BEAT_W-1:0] beats_q;
    logic                  drain_q;

    logic last_ch;
    logic last_j;
    logic next_j_last;

    assign last_ch     = (ch_q == num_ch_q - CH_W'(1));
    assign last_j      = (j_q == beats_q - J_ONE);
    assign next_j_last = (j_q + J_ONE == beats_q - J_ONE);

    // NOTE: sequential state uses non-blocking assignments and an asynchronous
    // reset branch; every register is listed there so reset leaves no X.
    always_ff @(posedge clk or negedge irst_n) begin
        if (!irst_n) begin
            state      <= IDLE;
            ch_q       <= '0;
            k_q        <= '0;
            j_q        <= '0;
            base_q     <= '0;
            num_ch_q   <= '0;
            beats_q    <= '0;
            drain_q    <= 1'b0;
            w_rd_en    <= 1'b0;
            w_rd_addr  <= '0;
            a_rd_en    <= 1'b0;
            a_rd_addr  <= '0;
            tag        <= '0;
            pixels     <= '0;
            busy       <= 1'b0;
            empty_done <= 1'b0;
        end else begin
            empty_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_channels != '0 && act_beats != '0) begin
                            num_ch_q  <= num_channels;
                            beats_q   <= act_beats;
                            pixels    <= PIXELS_W'(act_beats) + PIXELS_W'(WEIGHT_BEATS);
                            busy      <= 1'b1;
                            ch_q      <= '0;
                            k_q       <= '0;
                            base_q    <= '0;
                            w_rd_en   <= 1'b1;
                            w_rd_addr <= '0;
                            tag       <= '{kind: BEAT_WEIGHT, ch: '0, last: 1'b0};
                            state     <= FETCH_W;
                        end else begin
                            // Nothing to stream: acknowledge immediately.
                            empty_done <= 1'b1;
                        end
                    end
                end

                FETCH_W: begin
                    if (k_q == K_W'(WEIGHT_BEATS - 1)) begin
                        w_rd_en   <= 1'b0;
                        a_rd_en   <= 1'b1;
                        a_rd_addr <= base_q;
                        j_q       <= '0;
                        tag       <= '{kind: BEAT_ACT, ch: ch_q,
                                       last: last_ch && (beats_q == J_ONE)};
                        state     <= FETCH_A;
                    end else begin
                        k_q       <= k_q + K_W'(1);
                        w_rd_addr <= {ch_q, k_q + K_W'(1)};
                    end
                end

                FETCH_A: begin
                    if (last_j) begin
                        a_rd_en <= 1'b0;
                        if (!last_ch) begin
                            // Next channel's weight read follows with no gap.
                            ch_q      <= ch_q + CH_W'(1);
                            base_q    <= base_q + A_ADDR_W'(beats_q);
                            k_q       <= '0;
                            w_rd_en   <= 1'b1;
                            w_rd_addr <= {ch_q + CH_W'(1), K_W'(0)};
                            tag       <= '{kind: BEAT_WEIGHT, ch: ch_q + CH_W'(1), last: 1'b0};
                            state     <= FETCH_W;
                        end else begin
                            tag     <= '0;
                            drain_q <= 1'b0;
                            state   <= DRAIN;
                        end
                    end else begin
                        j_q       <= j_q + J_ONE;
                        a_rd_addr <= a_rd_addr + A_ADDR_W'(1);
                        tag.last  <= last_ch && next_j_last;
                    end
                end

                DRAIN: begin
                    // Two cycles cover the read latency plus the output register,
                    // so busy drops together with the done pulse.
                    if (drain_q) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sparse_pe_feeder.sv
// -----------------------------------------------------------------------------
// sparse_pe_feeder
// Transmitter side of the PE input stream. Reads compressed weights and
// activations from two 1-cycle-latency memories and emits, per channel,
// 4 weight beats followed by act_beats 4-lane activation beats, contiguously.
// Ports:
//   clk, irst_n                 clock, async active-low reset
//   start, num_channels,
//   act_beats                   layer request and shape (sampled on start)
//   w_rd_en/addr/data           weight memory port, data = {value,row,col}
//   a_rd_en/addr/data           activation memory port, 4 lanes of {value,row,col}
//   in_valid, pixels,
//   in_channel                  PE stream control
//   weight, weight_rows/cols    weight beat payload (0 on activation beats)
//   data_in, data_in_rows/cols  activation beat payload (0 on weight beats)
//   busy, done                  run status; done pulses after the last beat
// -----------------------------------------------------------------------------
module sparse_pe_feeder
    import sparse_pe_feeder_pkg::*;
#(
    parameter int col_length = 5,
    parameter int wordlength = 16,
    parameter int ACT_BEAT_W = 12,
    parameter int A_ADDR_W   = 18
) (
    input  logic                                      clk,
    input  logic                                      irst_n,
    input  logic                                      start,
    input  logic [CH_W-1:0]                           num_channels,
    input  logic [ACT_BEAT_W-1:0]                     act_beats,
    output logic                                      w_rd_en,
    output logic [W_ADDR_W-1:0]                       w_rd_addr,
    input  logic [wordlength+2*col_length-1:0]        w_rd_data,
    output logic                                      a_rd_en,
    output logic [A_ADDR_W-1:0]                       a_rd_addr,
    input  logic [LANES*(wordlength+2*col_length)-1:0] a_rd_data,
    output logic                                      in_valid,
    output logic [PIXELS_W-1:0]                       pixels,
    output logic [CH_W-1:0]                           in_channel,
    output logic [wordlength-1:0]                     weight,
    output logic [col_length-1:0]                     weight_rows,
    output logic [col_length-1:0]                     weight_cols,
    output logic [LANES*wordlength-1:0]               data_in,
    output logic [LANES*col_length-1:0]               data_in_rows,
    output logic [LANES*col_length-1:0]               data_in_cols,
    output logic                                      busy,
    output logic                                      done
);

    localparam int ELEM_W  = elem_w(wordlength, col_length);
    localparam int VAL_LSB = val_lsb(col_length);
    localparam int ROW_LSB = row_lsb(col_length);
    localparam int COL_LSB = FIELD_COL_LSB;

    beat_tag_t tag;
    logic      empty_done;

    sparse_feed_addr_gen #(
        .ACT_BEAT_W (ACT_BEAT_W),
        .A_ADDR_W   (A_ADDR_W)
    ) u_addr_gen (
        .clk          (clk),
        .irst_n       (irst_n),
        .start        (start),
        .num_channels (num_channels),
        .act_beats    (act_beats),
        .w_rd_en      (w_rd_en),
        .w_rd_addr    (w_rd_addr),
        .a_rd_en      (a_rd_en),
        .a_rd_addr    (a_rd_addr),
        .tag          (tag),
        .pixels       (pixels),
        .busy         (busy),
        .empty_done   (empty_done)
    );

    // Stage 1 holds the tag while the memory returns data; stage 2 is the
    // output register loaded from that data.
    logic      s1_valid;
    beat_tag_t s1_tag;
    logic      out_last;
    logic      run_done;

    always_ff @(posedge clk or negedge irst_n) begin
        if (!irst_n) begin
            s1_valid     <= 1'b0;
            s1_tag       <= '0;
            in_valid     <= 1'b0;
            in_channel   <= '0;
            out_last     <= 1'b0;
            run_done     <= 1'b0;
            weight       <= '0;
            weight_rows  <= '0;
            weight_cols  <= '0;
            data_in      <= '0;
            data_in_rows <= '0;
            data_in_cols <= '0;
        end else begin
            s1_valid <= w_rd_en | a_rd_en;
            s1_tag   <= tag;

            in_valid   <= s1_valid;
            in_channel <= s1_valid ? s1_tag.ch : '0;
            out_last   <= s1_valid & s1_tag.last;
            run_done   <= out_last;

            // Payload of the other beat type, and idle cycles, read as zero.
            weight       <= '0;
            weight_rows  <= '0;
            weight_cols  <= '0;
            data_in      <= '0;
            data_in_rows <= '0;
            data_in_cols <= '0;

            if (s1_valid && s1_tag.kind == BEAT_WEIGHT) begin
                weight      <= w_rd_data[VAL_LSB +: wordlength];
                weight_rows <= w_rd_data[ROW_LSB +: col_length];
                weight_cols <= w_rd_data[COL_LSB +: col_length];
            end

            if (s1_valid && s1_tag.kind == BEAT_ACT) begin
                for (int i = 0; i < LANES; i++) begin
                    data_in[i*wordlength +: wordlength]      <= a_rd_data[i*ELEM_W + VAL_LSB +: wordlength];
                    data_in_rows[i*col_length +: col_length] <= a_rd_data[i*ELEM_W + ROW_LSB +: col_length];
                    data_in_cols[i*col_length +: col_length] <= a_rd_data[i*ELEM_W + COL_LSB +: col_length];
                end
            end
        end
    end

    assign done = run_done | empty_done;

endmodule

// File: tb/tb_sparse_pe_feeder.sv
// -----------------------------------------------------------------------------
// tb_sparse_pe_feeder
// Scoreboard bench: each accepted layer pushes the full expected beat stream
// and read-address streams, derived from the memory contents with plain
// arithmetic; a negedge monitor pops and compares whatever the DUT presents.
// -----------------------------------------------------------------------------
module tb_sparse_pe_feeder;

    localparam int CL  = 5;
    localparam int WL  = 16;
    localparam int EW  = WL + 2 * CL;
    localparam int ABW = 12;
    localparam int AAW = 18;

    logic              clk          = 1'b0;
    logic              irst_n       = 1'b0;
    logic              start        = 1'b0;
    logic [5:0]        num_channels = '0;
    logic [ABW-1:0]    act_beats    = '0;
    logic              w_rd_en;
    logic [7:0]        w_rd_addr;
    logic [EW-1:0]     w_rd_data    = '0;
    logic              a_rd_en;
    logic [AAW-1:0]    a_rd_addr;
    logic [4*EW-1:0]   a_rd_data    = '0;
    logic              in_valid;
    logic [15:0]       pixels;
    logic [5:0]        in_channel;
    logic [WL-1:0]     weight;
    logic [CL-1:0]     weight_rows;
    logic [CL-1:0]     weight_cols;
    logic [4*WL-1:0]   data_in;
    logic [4*CL-1:0]   data_in_rows;
    logic [4*CL-1:0]   data_in_cols;
    logic              busy;
    logic              done;

    sparse_pe_feeder dut (
        .clk          (clk),
        .irst_n       (irst_n),
        .start        (start),
        .num_channels (num_channels),
        .act_beats    (act_beats),
        .w_rd_en      (w_rd_en),
        .w_rd_addr    (w_rd_addr),
        .w_rd_data    (w_rd_data),
        .a_rd_en      (a_rd_en),
        .a_rd_addr    (a_rd_addr),
        .a_rd_data    (a_rd_data),
        .in_valid     (in_valid),
        .pixels       (pixels),
        .in_channel   (in_channel),
        .weight       (weight),
        .weight_rows  (weight_rows),
        .weight_cols  (weight_cols),
        .data_in      (data_in),
        .data_in_rows (data_in_rows),
        .data_in_cols (data_in_cols),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Memories with one cycle of read latency.
    logic [EW-1:0]   w_mem [256];
    logic [4*EW-1:0] a_mem [1024];

    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= w_mem[w_rd_addr];
        if (a_rd_en) a_rd_data <= a_mem[a_rd_addr[9:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string msg);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", msg, cyc);
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [5:0]  ch;
        logic        is_w;
        logic [15:0] w;
        logic [4:0]  wr;
        logic [4:0]  wc;
        logic [63:0] d;
        logic [19:0] dr;
        logic [19:0] dc;
    } beat_s;

    beat_s exp_q[$];
    int    exp_w_addr[$];
    int    exp_a_addr[$];
    int    exp_pixels = 0;

    // Monitor statistics for the current run.
    int   rd_cnt, first_rd, run_beats, first_v, last_v, done_cnt, done_cyc;
    bit   busy_seen, busy_at_done, cap_valid;
    logic [63:0] cap_d;
    logic [19:0] cap_r, cap_c;
    beat_s mon_e;

    task automatic clear_stats();
        rd_cnt = 0; first_rd = -1; run_beats = 0; first_v = -1; last_v = -1;
        done_cnt = 0; done_cyc = -1; busy_seen = 0; busy_at_done = 0; cap_valid = 0;
    endtask

    always @(negedge clk) begin
        if (irst_n) begin
            if (busy) busy_seen = 1;
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy;
            end
            if (w_rd_en && a_rd_en) fail_now("rd_overlap: both read enables high");
            if (w_rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
                if (exp_w_addr.size() == 0) fail_now($sformatf("w_rd_unexpected: addr %0d", w_rd_addr));
                else check("w_rd_addr", w_rd_addr, exp_w_addr.pop_front());
            end
            if (a_rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
                if (exp_a_addr.size() == 0) fail_now($sformatf("a_rd_unexpected: addr %0d", a_rd_addr));
                else check("a_rd_addr", a_rd_addr, exp_a_addr.pop_front());
            end
            if (in_valid) begin
                run_beats++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                if (exp_q.size() == 0) begin
                    fail_now("beat_unexpected: in_valid with empty scoreboard");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_channel", in_channel, mon_e.ch);
                    check("beat_weight", {weight, weight_rows, weight_cols}, {mon_e.w, mon_e.wr, mon_e.wc});
                    check("beat_data", data_in, mon_e.d);
                    check("beat_lane_coords", {data_in_rows, data_in_cols}, {mon_e.dr, mon_e.dc});
                    check("pixels", pixels, exp_pixels);
                    if (!mon_e.is_w && !cap_valid) begin
                        cap_valid = 1;
                        cap_d = data_in; cap_r = data_in_rows; cap_c = data_in_cols;
                    end
                end
            end else begin
                check("idle_weight_zero", {in_channel, weight, weight_rows, weight_cols}, '0);
                check("idle_data_zero", {data_in, data_in_rows, data_in_cols}, '0);
            end
        end
    end

    // Reference model: the stream a layer must produce, straight from the
    // channel/beat rules and the memory contents.
    task automatic push_layer(input int n, input int b);
        beat_s           e;
        logic [EW-1:0]   word;
        logic [4*EW-1:0] aw;
        int              elem;
        exp_pixels = b + 4;
        for (int ch = 0; ch < n; ch++) begin
            for (int k = 0; k < 4; k++) begin
                word   = w_mem[ch*4 + k];
                e.ch   = 6'(ch);
                e.is_w = 1'b1;
                e.w    = 16'(word / 1024);
                e.wr   = 5'((word / 32) % 32);
                e.wc   = 5'(word % 32);
                e.d    = '0; e.dr = '0; e.dc = '0;
                exp_q.push_back(e);
                exp_w_addr.push_back(ch*4 + k);
            end
            for (int j = 0; j < b; j++) begin
                aw     = a_mem[ch*b + j];
                e.ch   = 6'(ch);
                e.is_w = 1'b0;
                e.w    = '0; e.wr = '0; e.wc = '0;
                e.d    = '0; e.dr = '0; e.dc = '0;
                for (int i = 0; i < 4; i++) begin
                    elem = int'((aw >> (EW*i)) % (1 << EW));
                    e.d  = e.d  | (64'(elem / 1024) << (WL*i));
                    e.dr = e.dr | (20'((elem / 32) % 32) << (CL*i));
                    e.dc = e.dc | (20'(elem % 32) << (CL*i));
                end
                exp_q.push_back(e);
                exp_a_addr.push_back(ch*b + j);
            end
        end
    endtask

    task automatic fill_random();
        logic [127:0] t;
        for (int i = 0; i < 256; i++) w_mem[i] = EW'($urandom);
        for (int i = 0; i < 1024; i++) begin
            t = {$urandom, $urandom, $urandom, $urandom};
            a_mem[i] = t[4*EW-1:0];
        end
    endtask

    task automatic run_layer(input int n, input int b, input bit mid_start);
        int s, p, guard;
        p = b + 4;
        push_layer(n, b);
        clear_stats();
        @(posedge clk); #1;
        start = 1'b1; num_channels = 6'(n); act_beats = ABW'(b); s = cyc;
        @(posedge clk); #1;
        start = 1'b0; num_channels = 6'($urandom); act_beats = ABW'($urandom);
        guard = 0;
        while (done_cnt == 0 && guard < n*p + 20) begin
            start = (mid_start && guard == 4);
            if (start) begin num_channels = 6'd7; act_beats = ABW'(9); end
            @(posedge clk); #1;
            guard++;
        end
        start = 1'b0;
        if (done_cnt == 0) fail_now($sformatf("done_timeout: n=%0d b=%0d", n, b));
        repeat (3) @(posedge clk);
        #1;
        check("first_read_cycle", first_rd, s + 1);
        check("first_valid_cycle", first_v, s + 3);
        check("beat_count", run_beats, n*p);
        check("stream_contiguous", last_v - first_v + 1, n*p);
        check("read_count", rd_cnt, n*p);
        check("done_cycle", done_cyc, s + n*p + 3);
        check("done_single_pulse", done_cnt, 1);
        check("busy_clear_at_done", busy_at_done, 1'b0);
        check("busy_during_run", busy_seen, 1'b1);
        check("scoreboard_drained", exp_q.size() + exp_w_addr.size() + exp_a_addr.size(), 0);
    endtask

    task automatic run_empty(input int n, input int b);
        int s;
        clear_stats();
        @(posedge clk); #1;
        start = 1'b1; num_channels = 6'(n); act_beats = ABW'(b); s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("empty_done_count", done_cnt, 1);
        check("empty_done_cycle", done_cyc, s + 1);
        check("empty_no_reads", rd_cnt, 0);
        check("empty_no_beats", run_beats, 0);
        check("empty_no_busy", busy_seen, 1'b0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, {in_valid, busy, done, w_rd_en, a_rd_en, pixels, in_channel,
                                weight, weight_rows, weight_cols}, '0);
        check({name, "_data"}, {data_in, data_in_rows, data_in_cols}, '0);
    endtask

    task automatic reset_mid_run();
        int guard;
        fill_random();
        push_layer(3, 3);
        clear_stats();
        @(posedge clk); #1;
        start = 1'b1; num_channels = 6'd3; act_beats = ABW'(3);
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(in_valid && in_channel == 6'd1) && guard < 100);
        check("reset_reached_channel1", {in_valid, in_channel}, {1'b1, 6'd1});
        #2 irst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_run_outputs");
        check("reset_mid_run_addrs", {w_rd_addr, a_rd_addr}, '0);
        exp_q.delete(); exp_w_addr.delete(); exp_a_addr.delete();
        repeat (2) @(posedge clk);
        #1;
        clear_stats();
        irst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("reset_no_done", done_cnt, 0);
        check("reset_no_reads", rd_cnt, 0);
        check("reset_no_beats", run_beats, 0);
        run_layer(3, 3, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4*EW-1:0] aw;
        clear_stats();
        fill_random();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        irst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("idle_after_reset");

        // Directed: one channel, two activation beats, known contents.
        for (int k = 0; k < 4; k++) w_mem[k] = {16'(k + 1), 5'(k), 5'(k)};
        aw = '0;
        for (int i = 0; i < 4; i++)
            aw = aw | ((4*EW)'({16'(10 + i), 5'(1 + i), 5'(5 + i)}) << (EW*i));
        a_mem[0] = aw;
        run_layer(1, 2, 1'b0);
        check("lane_values", cap_d, 64'h000d_000c_000b_000a);
        check("lane_rows", cap_r, {5'd4, 5'd3, 5'd2, 5'd1});
        check("lane_cols", cap_c, {5'd8, 5'd7, 5'd6, 5'd5});

        // Three channels, three activation beats.
        fill_random();
        run_layer(3, 3, 1'b0);

        // Zero-sized requests.
        run_empty(0, 5);
        run_empty(4, 0);

        // Start pulsed again mid-run must be ignored.
        fill_random();
        run_layer(3, 3, 1'b1);

        // Reset during channel 1, then a fresh run.
        reset_mid_run();

        // Boundaries: minimal layer and full channel range.
        fill_random();
        run_layer(1, 1, 1'b0);
        run_layer(63, 1, 1'b0);

        // Randomized shapes.
        for (int r = 0; r < 5; r++) begin
            fill_random();
            run_layer($urandom_range(1, 6), $urandom_range(1, 8), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
